// File: rtl/aud_i2s_capture.sv
// -----------------------------------------------------------------------------
// aud_i2s_capture
//
// I2S capture and SRAM write sequencer for the WM8731 ADC path. Deserializes
// 16-bit samples from AUD_ADCDAT (MSB first, one BCLK after the LRCK edge),
// then presents one word with a single-cycle write strobe per sample. Keeps
// the record address and take length under start / pause / stop control.
//
// Build option:
//   AUD_CAP_STEREO_EN  - when defined, capture left (even address) and right
//                        (following odd address) words every frame. When
//                        undefined, only the left channel is captured.
//
// Parameters:
//   ADDR_W    SRAM word-address width
//   MAX_ADDR  last writable address (must be odd in the stereo build)
//
// Ports:
//   i_AUD_BCLK  bit clock, all logic on its rising edge
//   i_rst_n     asynchronous reset, asserted while HIGH (legacy name)
//   i_lrc       AUD_ADCLRCK, low = left channel
//   i_data      AUD_ADCDAT, MSB first
//   i_start     begin a new take (IDLE) or resume (PAUSED)
//   i_pause     pause at the next sample boundary
//   i_stop      abort immediately, partial sample discarded
//   o_address   SRAM write address, valid while o_we = 1
//   o_data      captured sample, holds between strobes
//   o_we        one-cycle write strobe
//   o_busy      high in WAIT, SHIFT and STORE
//   o_full      sticky, set once MAX_ADDR has been written
//   o_len       number of words written in the current take
// -----------------------------------------------------------------------------
module aud_i2s_capture #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [15:0]       o_data,
  output logic              o_we,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len
);

`ifdef AUD_CAP_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_STORE,
    S_PAUSED
  } state_t;

  state_t            state_q, state_d;
  logic              lrc_q;
  logic [15:0]       shift_q, shift_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;    // pause requested during a sample
  logic              ch_q, ch_d;        // 0 = left word next, 1 = right word next
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   len_q, len_d;

  logic left_edge, right_edge, frame_edge, last_word;

  assign left_edge  = lrc_q & ~i_lrc;
  assign right_edge = ~lrc_q & i_lrc;
  // In stereo, the second word of the frame is framed by the rising LRCK edge.
  assign frame_edge = (STEREO && ch_q) ? right_edge : left_edge;
  // Full and pause only act on the last word of a frame.
  assign last_word  = !STEREO || ch_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    full_d  = full_q;
    len_d   = len_q;

    // Address and length advance the cycle after the strobe. A write at
    // MAX_ADDR leaves the address parked there.
    if (we_q) begin
      len_d = len_q + LEN_ONE;
      if (!full_q) addr_d = addr_q + ADDR_ONE;
    end

    if (i_stop) begin
      // Stop wins over everything; a partial sample is simply dropped.
      state_d = S_IDLE;
      pend_d  = 1'b0;
      ch_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start && !i_pause) begin
            addr_d  = '0;
            len_d   = '0;
            full_d  = 1'b0;
            pend_d  = 1'b0;
            ch_d    = 1'b0;
            state_d = S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_pause && last_word) begin
            state_d = S_PAUSED;
          end else begin
            // Between left and right words the pause is deferred.
            if (i_pause) pend_d = 1'b1;
            if (frame_edge) begin
              cnt_d   = '0;
              state_d = S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (i_pause) pend_d = 1'b1;
          shift_d = {shift_q[14:0], i_data};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = S_STORE;
        end

        S_STORE: begin
          we_d   = 1'b1;
          data_d = shift_q;
          if (last_word && addr_q == MAX_ADDR) begin
            full_d  = 1'b1;
            pend_d  = 1'b0;
            ch_d    = 1'b0;
            state_d = S_IDLE;
          end else if (!last_word) begin
            ch_d    = 1'b1;
            pend_d  = pend_q | i_pause;
            state_d = S_WAIT;
          end else if (pend_q || i_pause) begin
            pend_d  = 1'b0;
            ch_d    = 1'b0;
            state_d = S_PAUSED;
          end else begin
            ch_d    = 1'b0;
            state_d = S_WAIT;
          end
        end

        S_PAUSED: begin
          if (i_start && !i_pause) state_d = S_WAIT;
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_SHIFT) || (state_d == S_STORE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_AUD_BCLK or posedge i_rst_n) begin
    if (i_rst_n) begin
      state_q <= S_IDLE;
      lrc_q   <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ch_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      lrc_q   <= i_lrc;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      len_q   <= len_d;
    end
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_we      = we_q;
  assign o_busy    = busy_q;
  assign o_full    = full_q;
  assign o_len     = len_q;

endmodule

// File: tb/tb_aud_i2s_capture.sv
// -----------------------------------------------------------------------------
// tb_aud_i2s_capture
//
// Two instances share the I2S bus: instance 0 with the full address range and
// instance 1 with MAX_ADDR = 3. Commands go to the instance chosen by sel.
// A frame-level model decides, at the start of each frame, which words each
// instance will write and queues them; per-instance monitors pop and compare
// on every strobe.
// -----------------------------------------------------------------------------
module tb_aud_i2s_capture;

`ifdef AUD_CAP_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  localparam int          HALF  = 32;
  localparam logic [19:0] MAX_A = 20'hFFFFF;
  localparam logic [19:0] MAX_B = 20'd3;
  localparam int M_IDLE = 0, M_ACT = 1, M_PAUSED = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic lrc = 1'b1;
  logic dat = 1'b0;
  logic cmd_start = 1'b0, cmd_pause = 1'b0, cmd_stop = 1'b0;
  logic sel = 1'b0;

  logic [19:0] addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        we_a, we_b, busy_a, busy_b, full_a, full_b;
  logic [20:0] len_a, len_b;

  always #5 clk = ~clk;

  aud_i2s_capture #(.ADDR_W(20), .MAX_ADDR(MAX_A)) dut_a (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(dat),
    .i_start(cmd_start & ~sel), .i_pause(cmd_pause & ~sel), .i_stop(cmd_stop & ~sel),
    .o_address(addr_a), .o_data(data_a), .o_we(we_a), .o_busy(busy_a),
    .o_full(full_a), .o_len(len_a)
  );

  aud_i2s_capture #(.ADDR_W(20), .MAX_ADDR(MAX_B)) dut_b (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_data(dat),
    .i_start(cmd_start & sel), .i_pause(cmd_pause & sel), .i_stop(cmd_stop & sel),
    .o_address(addr_b), .o_data(data_b), .o_we(we_b), .o_busy(busy_b),
    .o_full(full_b), .o_len(len_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          mst[2];
  logic [19:0] maddr[2];
  logic [20:0] mlen[2];
  logic        mfull[2];
  logic [35:0] exp_a[$];
  logic [35:0] exp_b[$];

  task automatic model_frame(input int s, input logic [15:0] l, input logic [15:0] r,
                             input int pause_at, input int stop_at,
                             input bit do_start, input bit pause_wait);
    logic [15:0] w[2];
    logic [19:0] mx;
    int nw;
    mx = (s == 1) ? MAX_B : MAX_A;
    w[0] = l;
    w[1] = r;
    nw = STEREO ? 2 : 1;
    if (mst[s] == M_ACT && stop_at == 0) begin
      for (int i = 0; i < nw; i++) begin
        if (s == 1) exp_b.push_back({maddr[s], w[i]});
        else        exp_a.push_back({maddr[s], w[i]});
        mlen[s] = mlen[s] + 21'd1;
        if (maddr[s] == mx) begin
          mfull[s] = 1'b1;
          mst[s] = M_IDLE;
          break;
        end
        maddr[s] = maddr[s] + 20'd1;
      end
      if (mst[s] == M_ACT && pause_at > 0) mst[s] = M_PAUSED;
    end
    if (stop_at > 0) mst[s] = M_IDLE;
    if (do_start) begin
      if (mst[s] == M_IDLE) begin
        maddr[s] = '0;
        mlen[s] = '0;
        mfull[s] = 1'b0;
        mst[s] = M_ACT;
      end else if (mst[s] == M_PAUSED) begin
        mst[s] = M_ACT;
      end
    end
    if (pause_wait && mst[s] == M_ACT) mst[s] = M_PAUSED;
  endtask

  task automatic check_state(input int s);
    check($sformatf("address_%0d", s), (s == 1) ? addr_b : addr_a, maddr[s]);
    check($sformatf("len_%0d", s), (s == 1) ? len_b : len_a, mlen[s]);
    check($sformatf("full_%0d", s), (s == 1) ? full_b : full_a, mfull[s]);
    check($sformatf("busy_%0d", s), (s == 1) ? busy_b : busy_a, (mst[s] == M_ACT));
  endtask

  // One I2S frame: left half (lrc low) then right half (lrc high), MSB one
  // BCLK after each LRCK edge. pause_at / stop_at are left-half bit indices
  // (0 = none); start pulses mid right half, pause_wait after the right word.
  task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                           input int pause_at, input int stop_at,
                           input bit do_start, input bit pause_wait);
    for (int s = 0; s < 2; s++) begin
      if (s == int'(sel)) model_frame(s, l, r, pause_at, stop_at, do_start, pause_wait);
      else                model_frame(s, l, r, 0, 0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2 * HALF; k++) begin
      @(negedge clk);
      if (k < HALF) begin
        lrc = 1'b0;
        dat = (k >= 1 && k <= 16) ? l[16-k] : 1'($urandom_range(0, 1));
      end else begin
        lrc = 1'b1;
        dat = (k - HALF >= 1 && k - HALF <= 16) ? r[16-(k-HALF)] : 1'($urandom_range(0, 1));
      end
      cmd_pause = (pause_at > 0 && k == pause_at) || (pause_wait && k == HALF + 20);
      cmd_stop  = (stop_at > 0 && k == stop_at);
      cmd_start = do_start && (k == HALF + 10);
      if (stop_at > 0 && k == stop_at + 1)
        check("busy_after_stop", sel ? busy_b : busy_a, 0);
    end
    check_state(0);
    check_state(1);
  endtask

  // ---------------- monitors ----------------
  logic prev_we_a = 1'b0, prev_we_b = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      prev_we_a <= 1'b0;
    end else begin
      if (we_a) begin
        check("strobe_0_expected", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) check("write_0_addr_data", {addr_a, data_a}, exp_a.pop_front());
        check("strobe_0_single_cycle", prev_we_a, 0);
      end
      prev_we_a <= we_a;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      prev_we_b <= 1'b0;
    end else begin
      if (we_b) begin
        check("strobe_1_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("write_1_addr_data", {addr_b, data_b}, exp_b.pop_front());
        check("strobe_1_single_cycle", prev_we_b, 0);
      end
      prev_we_b <= we_b;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pa, sa;
    bit ds, pw;
    for (int s = 0; s < 2; s++) begin
      mst[s] = M_IDLE;
      maddr[s] = '0;
      mlen[s] = '0;
      mfull[s] = 1'b0;
    end

    // Reset held, then released: everything zero.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_address_0", addr_a, 0);
    check("reset_data_0", data_a, 0);
    check("reset_we_0", we_a, 0);
    check("reset_busy_0", busy_a, 0);
    check("reset_full_0", full_a, 0);
    check("reset_len_0", len_a, 0);
    check("reset_address_1", addr_b, 0);
    check("reset_data_1", data_b, 0);
    check("reset_we_1", we_b, 0);
    check("reset_busy_1", busy_b, 0);
    check("reset_full_1", full_b, 0);
    check("reset_len_1", len_b, 0);

    // Instance 0: directed take, pause, resume, stop.
    sel = 1'b0;
    run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);
    run_frame(16'h8001, 16'($urandom), 0, 0, 1'b0, 1'b0);
    run_frame(16'h7FFE, 16'($urandom), 0, 0, 1'b0, 1'b0);
    check("len_after_two_frames", len_a, STEREO ? 4 : 2);
    run_frame(16'($urandom), 16'($urandom), 5, 0, 1'b0, 1'b0);
    run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);
    run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b0, 1'b0);
    run_frame(16'($urandom), 16'($urandom), 0, 10, 1'b0, 1'b0);
    check("len_kept_after_stop", len_a, STEREO ? 8 : 4);

    // Instance 0: randomized commands.
    repeat (24) begin
      pa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 16)) : 0;
      sa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 16)) : 0;
      ds = ($urandom_range(0, 2) == 0) && (pa == 0);
      pw = ($urandom_range(0, 5) == 0);
      run_frame(16'($urandom), 16'($urandom), pa, sa, ds, pw);
    end

    // Instance 1: run to full at address 3, then restart.
    sel = 1'b1;
    run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);
    repeat (6) run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b0, 1'b0);
    check("full_set_at_max", full_b, 1);
    check("address_parked_at_max", addr_b, 3);
    run_frame(16'($urandom), 16'($urandom), 0, 0, 1'b1, 1'b0);
    check("full_cleared_by_start", full_b, 0);
    run_frame(16'h1234, 16'hABCD, 0, 0, 1'b0, 1'b0);
    check("len_after_restart", len_b, STEREO ? 2 : 1);

    repeat (4) @(negedge clk);
    check("queue_0_drained", exp_a.size(), 0);
    check("queue_1_drained", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
